// File: rtl/fifo_skew_ctrl.sv
// Sequencer for a bank of shift-register delay FIFOs: clears the bank, steers
// lane-addressed load words into it, then drains every lane with a diagonal skew.
module fifo_skew_ctrl #(
    parameter int LANES = 8,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(LANES),
    parameter int TW    = $clog2(DEPTH + LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             load_valid,
    input  logic [LW-1:0]    load_lane,
    output logic             load_ready,
    output logic [LANES-1:0] fifo_en,
    output logic             fifo_clr,
    output logic             load_sel,
    output logic [LANES-1:0] feed_valid,
    output logic             busy,
    output logic             done,
    output logic             load_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST   = TW'(DEPTH + LANES - 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_FEED  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          abort_clr_q, abort_clr_d;
    logic [TW-1:0] t_q, t_d;
    logic          load_err_q, load_err_d;
    logic [CW-1:0] cnt_q [LANES];
    logic [CW-1:0] cnt_d [LANES];
    logic          lane_hit;
    logic          lane_full;
    logic          all_full;

    // A CLEAR entered through abort returns to IDLE instead of starting a load.
    always_comb begin
        state_d     = state_q;
        abort_clr_d = abort_clr_q;
        t_d         = '0;
        load_err_d  = load_err_q;
        fifo_en     = '0;
        lane_hit    = 1'b0;
        lane_full   = 1'b0;
        all_full    = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < LANES; i++) begin
            if (int'(load_lane) == i) begin
                lane_hit  = 1'b1;
                lane_full = (cnt_q[i] == CNT_FULL);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CLEAR;
                    abort_clr_d = 1'b0;
                    load_err_d  = 1'b0;
                end
            end
            S_CLEAR: begin
                for (int i = 0; i < LANES; i++) begin
                    cnt_d[i] = '0;
                end
                state_d = abort_clr_q ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                if (load_valid) begin
                    if (lane_hit && !lane_full) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (int'(load_lane) == i) begin
                                fifo_en[i] = 1'b1;
                                cnt_d[i]   = cnt_q[i] + CW'(1);
                            end
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                // Leave LOAD right after the cycle that writes the last word.
                for (int i = 0; i < LANES; i++) begin
                    if (cnt_d[i] != CNT_FULL) begin
                        all_full = 1'b0;
                    end
                end
                if (all_full) begin
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                for (int i = 0; i < LANES; i++) begin
                    fifo_en[i] = (int'(t_q) >= i) && (int'(t_q) < i + DEPTH);
                end
                if (t_q == T_LAST) begin
                    state_d = S_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_CLEAR;
            abort_clr_d = 1'b1;
            t_d         = '0;
            load_err_d  = load_err_q;
            fifo_en     = '0;
            for (int i = 0; i < LANES; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        fifo_clr   = (state_q == S_CLEAR);
        load_ready = (state_q == S_LOAD);
        load_sel   = (state_q == S_LOAD);
        feed_valid = (state_q == S_FEED) ? fifo_en : '0;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        load_err   = load_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            abort_clr_q <= 1'b0;
            t_q         <= '0;
            load_err_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            abort_clr_q <= abort_clr_d;
            t_q         <= t_d;
            load_err_q  <= load_err_d;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
